// File: rtl/ifetch_sequencer_if.sv
// Instruction-memory port bundle: the sequencer is the master (address/write side),
// the memory is the slave (combinational read data).
interface ifetch_sequencer_if;
    logic [31:0] imem_addr;
    logic        imem_we;
    logic [31:0] imem_wdata;
    logic [31:0] imem_rdata;

    modport master (output imem_addr, output imem_we, output imem_wdata, input imem_rdata);
    modport slave  (input imem_addr, input imem_we, input imem_wdata, output imem_rdata);
endinterface

// File: rtl/ifetch_sequencer.sv
// Instruction-fetch controller: boot-time program load into instruction memory,
// then one fetch per cycle into IF/ID with stall, redirect, halt and fault handling.
module ifetch_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] HALT_INSTR  = 32'h0000_000C
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_load_valid,
    input  logic [9:0]                 i_load_addr,
    input  logic [31:0]                i_load_data,
    output logic                       o_load_ready,
    input  logic                       i_boot_done,
    input  logic                       i_stall,
    input  logic                       i_redirect_valid,
    input  logic [31:0]                i_redirect_pc,
    ifetch_sequencer_if.master         imem,
    output logic                       o_if_valid,
    output logic [31:0]                o_if_pc,
    output logic [31:0]                o_if_instr,
    output logic                       o_halted,
    output logic                       o_fault,
    output logic [31:0]                o_fetch_count
);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic        r_if_valid, w_if_valid_nxt;
    logic [31:0] r_if_pc, w_if_pc_nxt;
    logic [31:0] r_if_instr, w_if_instr_nxt;
    logic        r_fault, w_fault_nxt;
    logic [31:0] r_fetch_count, w_fetch_count_nxt;

    logic [31:0] w_pc_plus4;
    logic        w_redirect_bad;
    logic        w_next_oob;
    logic [31:0] w_count_inc;

    assign w_pc_plus4     = r_pc + 32'd4;
    assign w_redirect_bad = (i_redirect_pc[1:0] != 2'b00) || ((i_redirect_pc >> 2) >= DEPTH_WORDS);
    assign w_next_oob     = (w_pc_plus4 >> 2) >= DEPTH_WORDS;
    assign w_count_inc    = (r_fetch_count == 32'hFFFF_FFFF) ? r_fetch_count : r_fetch_count + 32'd1;

    // State and IF/ID register update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_LOAD;
            r_pc          <= RESET_PC;
            r_if_valid    <= 1'b0;
            r_if_pc       <= 32'd0;
            r_if_instr    <= 32'd0;
            r_fault       <= 1'b0;
            r_fetch_count <= 32'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_if_valid    <= w_if_valid_nxt;
            r_if_pc       <= w_if_pc_nxt;
            r_if_instr    <= w_if_instr_nxt;
            r_fault       <= w_fault_nxt;
            r_fetch_count <= w_fetch_count_nxt;
        end
    end

    // Next-state, fetch sequencing and memory-port drive
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_if_valid_nxt    = r_if_valid;
        w_if_pc_nxt       = r_if_pc;
        w_if_instr_nxt    = r_if_instr;
        w_fault_nxt       = r_fault;
        w_fetch_count_nxt = r_fetch_count;
        imem.imem_addr    = 32'd0;
        imem.imem_we      = 1'b0;
        imem.imem_wdata   = 32'd0;

        case (r_state)
            S_LOAD: begin
                if (i_load_valid) begin
                    imem.imem_we    = 1'b1;
                    imem.imem_addr  = {20'd0, i_load_addr, 2'b00};
                    imem.imem_wdata = i_load_data;
                end else begin
                    imem.imem_we    = 1'b0;
                end
                if (i_boot_done) begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = RESET_PC;
                end else begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_RUN: begin
                imem.imem_addr = r_pc;
                // Redirect flushes the wrong-path slot even while the hazard unit stalls
                if (i_redirect_valid) begin
                    w_pc_nxt       = i_redirect_pc;
                    w_if_valid_nxt = 1'b0;
                    if (w_redirect_bad) begin
                        w_fault_nxt = 1'b1;
                        w_state_nxt = S_HALT;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end else if (i_stall) begin
                    w_pc_nxt = r_pc;
                end else begin
                    w_if_instr_nxt    = imem.imem_rdata;
                    w_if_pc_nxt       = r_pc;
                    w_if_valid_nxt    = 1'b1;
                    w_pc_nxt          = w_pc_plus4;
                    w_fetch_count_nxt = w_count_inc;
                    if (w_next_oob) begin
                        w_fault_nxt = 1'b1;
                        w_state_nxt = S_HALT;
                    end else if (imem.imem_rdata == HALT_INSTR) begin
                        w_state_nxt = S_HALT;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_HALT: begin
                imem.imem_addr = r_pc;
                if (!i_stall) begin
                    w_if_valid_nxt = 1'b0;
                end else begin
                    w_if_valid_nxt = r_if_valid;
                end
            end
            default: begin
                w_state_nxt = S_HALT;
            end
        endcase
    end

    assign o_load_ready  = (r_state == S_LOAD);
    assign o_halted      = (r_state == S_HALT);
    assign o_if_valid    = r_if_valid;
    assign o_if_pc       = r_if_pc;
    assign o_if_instr    = r_if_instr;
    assign o_fault       = r_fault;
    assign o_fetch_count = r_fetch_count;

endmodule

// File: tb/tb_ifetch_sequencer.sv
// Bench for ifetch_sequencer: memory model, spec-level reference model checked every
// cycle, plus directed vectors with literal expectations.
module tb_ifetch_sequencer;

    localparam logic [31:0] HALT_W = 32'h0000_000C;
    localparam logic [31:0] FILL_W = 32'h0000_0013;
    localparam int M_LOAD = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic        clk = 1'b0;
    logic        rst, load_valid, boot_done, stall, redirect_valid;
    logic [9:0]  load_addr;
    logic [31:0] load_data, redirect_pc;
    logic        load_ready, if_valid, halted, fault;
    logic [31:0] if_pc, if_instr, fetch_count;

    int n_vec  = 0;
    int n_miss = 0;
    logic chk_en = 1'b0;

    logic [31:0] prog [0:3];

    ifetch_sequencer_if bus ();

    ifetch_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .i_load_valid     (load_valid),
        .i_load_addr      (load_addr),
        .i_load_data      (load_data),
        .o_load_ready     (load_ready),
        .i_boot_done      (boot_done),
        .i_stall          (stall),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .imem             (bus),
        .o_if_valid       (if_valid),
        .o_if_pc          (if_pc),
        .o_if_instr       (if_instr),
        .o_halted         (halted),
        .o_fault          (fault),
        .o_fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    // Instruction memory: combinational read, write captured at the edge
    logic [31:0] mem [0:1023];
    logic mem_inited = 1'b0;
    always @(posedge clk) begin
        if (!mem_inited) begin
            for (int i = 0; i < 1024; i++) mem[i] <= FILL_W;
            mem_inited <= 1'b1;
        end else if (bus.imem_we) begin
            mem[bus.imem_addr[11:2]] <= bus.imem_wdata;
        end
    end
    assign bus.imem_rdata = mem[bus.imem_addr[11:2]];

    // Reference model: what the controller must hold after each edge
    int          m_mode;
    logic [31:0] m_pc, m_ifpc, m_instr, m_cnt;
    logic        m_v, m_fault;
    logic [31:0] m_mem [0:1023];
    logic        m_inited = 1'b0;

    always @(posedge clk) begin
        if (!m_inited) begin
            for (int i = 0; i < 1024; i++) m_mem[i] <= FILL_W;
            m_inited <= 1'b1;
        end
        if (rst) begin
            m_mode <= M_LOAD; m_pc <= 32'd0; m_v <= 1'b0; m_ifpc <= 32'd0;
            m_instr <= 32'd0; m_fault <= 1'b0; m_cnt <= 32'd0;
        end else if (m_mode == M_LOAD) begin
            if (load_valid && m_inited) m_mem[load_addr] <= load_data;
            if (boot_done) begin
                m_mode <= M_RUN;
                m_pc   <= 32'd0;
            end
        end else if (m_mode == M_RUN) begin
            if (redirect_valid) begin
                m_v  <= 1'b0;
                m_pc <= redirect_pc;
                if ((redirect_pc % 32'd4) != 32'd0 || (redirect_pc / 32'd4) >= 32'd1024) begin
                    m_fault <= 1'b1;
                    m_mode  <= M_HALT;
                end
            end else if (!stall) begin
                m_instr <= m_mem[m_pc[11:2]];
                m_ifpc  <= m_pc;
                m_v     <= 1'b1;
                m_pc    <= m_pc + 32'd4;
                if (m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 32'd1;
                if ((m_pc + 32'd4) / 32'd4 >= 32'd1024) begin
                    m_fault <= 1'b1;
                    m_mode  <= M_HALT;
                end else if (m_mem[m_pc[11:2]] == HALT_W) begin
                    m_mode <= M_HALT;
                end
            end
        end else begin
            if (!stall) m_v <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, mid-cycle
    always @(negedge clk) begin
        if (chk_en) begin
            logic        e_load;
            logic [31:0] e_addr;
            e_load = (m_mode == M_LOAD);
            e_addr = e_load ? (load_valid ? {20'd0, load_addr, 2'b00} : 32'd0) : m_pc;
            chk("load_ready", {31'd0, load_ready}, {31'd0, e_load});
            chk("imem_we", {31'd0, bus.imem_we}, {31'd0, e_load && load_valid});
            chk("imem_addr", bus.imem_addr, e_addr);
            chk("imem_wdata", bus.imem_wdata, (e_load && load_valid) ? load_data : 32'd0);
            chk("if_valid", {31'd0, if_valid}, {31'd0, m_v});
            chk("if_pc", if_pc, m_ifpc);
            chk("if_instr", if_instr, m_instr);
            chk("halted", {31'd0, halted}, {31'd0, m_mode == M_HALT});
            chk("fault", {31'd0, fault}, {31'd0, m_fault});
            chk("fetch_count", fetch_count, m_cnt);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic reset_and_boot();
        rst = 1'b1; step(1);
        rst = 1'b0; boot_done = 1'b1; step(1);
        boot_done = 1'b0;
    endtask

    initial begin
        prog[0] = 32'h0109_5020; prog[1] = 32'hAC0A_0000;
        prog[2] = 32'h0149_5822; prog[3] = 32'h0000_000C;
        rst = 1'b1; load_valid = 1'b0; boot_done = 1'b0; stall = 1'b0;
        redirect_valid = 1'b0; load_addr = 10'd0; load_data = 32'd0; redirect_pc = 32'd0;
        step(1);
        chk_en = 1'b1;
        step(1);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_load_ready", {31'd0, load_ready}, 32'd1);
        chk("rst_if_instr", if_instr, 32'd0);
        rst = 1'b0;

        // Load program; last word shares its cycle with boot_done
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1; load_addr = i[9:0]; load_data = prog[i];
            boot_done = (i == 3);
            step(1);
        end
        load_valid = 1'b0; boot_done = 1'b0;
        chk("run_load_ready", {31'd0, load_ready}, 32'd0);
        chk("run_first_valid", {31'd0, if_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("seq_if_pc", if_pc, 32'(i * 4));
            chk("seq_if_instr", if_instr, prog[i]);
            chk("seq_count", fetch_count, 32'(i + 1));
        end
        chk("seq_halted", {31'd0, halted}, 32'd1);
        chk("seq_fault", {31'd0, fault}, 32'd0);
        step(1);
        chk("seq_halt_valid", {31'd0, if_valid}, 32'd0);

        // Stall at if_pc=4 with loader writes attempted in RUN
        reset_and_boot();
        step(2);
        chk("stall_pre_pc", if_pc, 32'h4);
        stall = 1'b1; load_valid = 1'b1; load_addr = 10'd2; load_data = HALT_W;
        for (int k = 0; k < 3; k++) begin
            step(1);
            chk("stall_pc", if_pc, 32'h4);
            chk("stall_instr", if_instr, prog[1]);
            chk("stall_count", fetch_count, 32'd2);
        end
        stall = 1'b0; load_valid = 1'b0;
        step(1);
        chk("unstall_pc", if_pc, 32'h8);
        chk("gated_write", if_instr, prog[2]);

        // Redirect beats stall
        redirect_valid = 1'b1; redirect_pc = 32'd0; stall = 1'b1;
        step(1);
        chk("redir_flush", {31'd0, if_valid}, 32'd0);
        redirect_valid = 1'b0; stall = 1'b0;
        step(1);
        chk("redir_pc", if_pc, 32'd0);
        chk("redir_valid", {31'd0, if_valid}, 32'd1);

        // Reset mid-run at fetch_count=2; program survives
        reset_and_boot();
        step(2);
        chk("mid_count", fetch_count, 32'd2);
        rst = 1'b1; step(1); rst = 1'b0;
        chk("mid_rst_count", fetch_count, 32'd0);
        chk("mid_rst_pc", if_pc, 32'd0);
        chk("mid_rst_halted", {31'd0, halted}, 32'd0);
        boot_done = 1'b1; step(1); boot_done = 1'b0;
        step(1);
        chk("refetch_instr", if_instr, prog[0]);

        // Misaligned redirect faults; later redirects ignored in HALT
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0006;
        step(1);
        chk("mis_fault", {31'd0, fault}, 32'd1);
        chk("mis_halted", {31'd0, halted}, 32'd1);
        chk("mis_valid", {31'd0, if_valid}, 32'd0);
        redirect_pc = 32'd0;
        step(2);
        redirect_valid = 1'b0;
        chk("halt_sticky", {31'd0, halted}, 32'd1);

        // Out-of-range redirect faults
        reset_and_boot();
        step(1);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_1000;
        step(1);
        redirect_valid = 1'b0;
        chk("oor_fault", {31'd0, fault}, 32'd1);
        chk("oor_halted", {31'd0, halted}, 32'd1);

        // Run off the end of memory; HALT stall keeps IF/ID live
        reset_and_boot();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0FF8;
        step(1);
        redirect_valid = 1'b0;
        step(1);
        chk("end_pc_1022", if_pc, 32'h0FF8);
        chk("end_fault_early", {31'd0, fault}, 32'd0);
        step(1);
        chk("end_pc_1023", if_pc, 32'h0FFC);
        chk("end_instr", if_instr, FILL_W);
        chk("end_fault", {31'd0, fault}, 32'd1);
        chk("end_halted", {31'd0, halted}, 32'd1);
        stall = 1'b1;
        step(1);
        chk("halt_stall_valid", {31'd0, if_valid}, 32'd1);
        stall = 1'b0;
        step(1);
        chk("halt_clear_valid", {31'd0, if_valid}, 32'd0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ifetch_sequencer.md
# ifetch_sequencer

Instruction-fetch controller sitting between the pipeline's IF stage and the single-port, asynchronous-read instruction memory (1024 words). It owns the memory port. It sequences a boot-time program load into memory, then drives the PC and fetches one word per cycle into the IF/ID register. It honours hazard stalls and branch redirects, and stops on a halt instruction or an addressing fault.

## Interface
- RESET_PC, 32'h0000_0000, byte address of the first fetch after boot
- DEPTH_WORDS, 1024, instruction memory depth in 32-bit words
- HALT_INSTR, 32'h0000_000C, encoding that stops fetch (syscall)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- load_valid  in  1  loader presents a word to write
- load_addr  in  10  loader word index
- load_data  in  32  loader word
- load_ready  out  1  sequencer accepts loader writes (LOAD state only)
- boot_done  in  1  loader finished; start fetching
- stall  in  1  hazard unit holds IF/ID
- redirect_valid  in  1  taken branch/jump from a later stage
- redirect_pc  in  32  redirect target byte address
- imem_addr  out  32  byte address to memory (memory indexes addr>>2)
- imem_we  out  1  memory write strobe
- imem_wdata  out  32  memory write data
- imem_rdata  in  32  memory read data, combinational from imem_addr
- if_valid  out  1  IF/ID holds a live instruction
- if_pc  out  32  PC of if_instr
- if_instr  out  32  fetched instruction
- halted  out  1  HALT state
- fault  out  1  sticky addressing fault
- fetch_count  out  32  instructions delivered to IF/ID

## Operation
- States: LOAD (reset state), RUN, HALT. There is no other state, and HALT exits only via rst.
- LOAD:
  - load_ready=1.
  - load_valid=1 drives imem_we=1, imem_addr={20'b0,load_addr,2'b00}, imem_wdata=load_data in the same cycle.
  - With load_valid=0, imem_we=0 and imem_addr=0.
  - boot_done=1 moves to RUN at the next edge, with pc=RESET_PC. A concurrent load_valid write still completes.
- RUN:
  - load_ready=0, imem_we=0, imem_wdata=0, imem_addr=pc. Loader writes are ignored.
  - Per-edge priority, highest first:
    1. redirect_valid:
       - pc<=redirect_pc and if_valid<=0 (flush), regardless of stall.
       - If redirect_pc[1:0]!=0 or redirect_pc>>2 >= DEPTH_WORDS: fault<=1, go to HALT.
    2. stall: pc, if_valid, if_pc, if_instr and fetch_count all hold.
    3. Fetch: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4 (32-bit wrap), fetch_count+=1.
       - If imem_rdata==HALT_INSTR: the halt word is still delivered with if_valid=1 and counted, then go to HALT.
  - Out of range: if pc+4 would give (pc+4)>>2 >= DEPTH_WORDS, the current fetch is still delivered, then fault<=1 and HALT.
- HALT:
  - halted=1, imem_we=0, imem_addr holds last pc.
  - if_valid<=0 at the first HALT edge unless stall=1. If stalled, the IF/ID contents hold until the first non-stalled edge, then clear.
  - redirect and load inputs are ignored.
- fetch_count saturates at 32'hFFFF_FFFF.

## Timing
- Reset values:
  - state=LOAD, pc=RESET_PC, if_valid=0, if_pc=0, if_instr=0 (NOP).
  - halted=0, fault=0, fetch_count=0, load_ready=1, imem_we=0, imem_addr=0, imem_wdata=0.
- Load write latency: 0 cycles. The strobe is combinational from load_valid in LOAD and the memory captures it at the edge.
- Fetch latency: 1 cycle, pc to if_instr. Throughput is 1 instruction/cycle with no stall.
- First fetch: the first RUN cycle presents RESET_PC, and if_valid=1 after that cycle's edge. boot_done high to first if_valid is 2 edges.
- Redirect: the target is presented the cycle after redirect_valid. The one wrong-path slot shows if_valid=0.
- rst mid-load or mid-run: everything returns to reset values at that edge and memory contents are untouched. A program therefore survives reset, but the loader must reassert boot_done.

## Test plan
- Load and run:
  - Stimulus: write words 0..3 = 01095020, AC0A0000, 01495822, 0000000C, then boot_done.
  - Response: if_pc 0,4,8,C on consecutive cycles with matching if_instr, halted=1 after C, fetch_count=4, fault=0.
- Stall:
  - Stimulus: during RUN, stall=1 for 3 cycles at if_pc=4.
  - Response: if_pc/if_instr/fetch_count hold for 3 cycles, then if_pc=8 on the next edge.
- Redirect:
  - Stimulus: redirect_valid=1, redirect_pc=0 while stall=1 and if_pc=8.
  - Response: next edge if_valid=0 (redirect beats stall), following edge if_pc=0.
- Faults:
  - Stimulus: redirect_pc=32'h0000_0006.
  - Response: fault=1, halted=1, if_valid=0.
  - Stimulus: redirect_pc=32'h0000_1000.
  - Response: same fault/HALT result.
  - Stimulus: running to word 1023 with no halt.
  - Response: word 1023 delivered, then fault=1, halted=1.
- Load gating:
  - Stimulus: load_valid=1 in RUN.
  - Response: imem_we stays 0 and load_ready=0.
  - Stimulus: load_valid and boot_done in the same LOAD cycle.
  - Response: write lands (read back via fetch) and RUN starts at the next edge.
- Reset mid-run:
  - Stimulus: rst at fetch_count=2.
  - Response: all outputs at reset values; after boot_done the program refetches from RESET_PC with no reload.
